// File: rtl/lcd_pkg.sv
// Shared types for the LCD frame capture block: one segment word per H phase,
// four phases per frame.
package lcd_pkg;

    localparam int H_PHASES = 4;
    localparam int SEG_W    = 33;

    // {bs, b[15:0], a[15:0]} for one H phase
    typedef logic [SEG_W-1:0] seg_word_t;

    // Index 0..3 is the H phase
    typedef seg_word_t [H_PHASES-1:0] frame_t;

endpackage

// File: rtl/lcd_frame_seq.sv
// H-phase sequencer. Tracks the last phase seen and which phases of the current
// frame arrived in order. It reports capture strobes, frame completion, a pulse
// when the strobes have been idle long enough to call the panel stale, and a
// count of out-of-order steps.
module lcd_frame_seq
    import lcd_pkg::*;
#(
    parameter int STALL_TICKS = 2048,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic [1:0]       lcd_h_index,
    output logic             capture_we,
    output logic [1:0]       capture_idx,
    output logic             frame_done,
    output logic             stall_hit,
    output logic [CNT_W-1:0] seq_err_count
);

    localparam int                 STALL_W   = $clog2(STALL_TICKS + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TICKS);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_TICKS - 1);

    logic [1:0]          prev_h;
    logic [H_PHASES-1:0] seen_mask;
    logic [H_PHASES-1:0] idx_onehot;
    logic [1:0]          exp_h;
    logic                step_ok;
    logic [STALL_W-1:0]  stall_cnt;

    // Any change of H index on a tick is a capture; the expected step is +1 mod 4,
    // so after reset (prev_h=0) a first index of 1 counts as in order.
    assign exp_h       = prev_h + 2'd1;
    assign step_ok     = (lcd_h_index == exp_h);
    assign capture_we  = clk_en && (lcd_h_index != prev_h);
    assign capture_idx = lcd_h_index;
    assign idx_onehot  = H_PHASES'(1) << lcd_h_index;
    assign frame_done  = capture_we && step_ok && (lcd_h_index == 2'd3) && (&seen_mask[2:0]);

    // Stall pulse fires on the tick that brings the idle counter to its limit.
    assign stall_hit   = clk_en && !capture_we && (stall_cnt == STALL_PRE);

    // Track last phase and the in-order phases collected for the current frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_h    <= 2'd0;
            seen_mask <= '0;
        end else if (capture_we) begin
            prev_h <= lcd_h_index;
            if (frame_done)
                seen_mask <= '0;
            else if (step_ok)
                seen_mask <= seen_mask | idx_onehot;
            else
                seen_mask <= idx_onehot;
        end
    end

    // Saturating count of out-of-order phase steps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            seq_err_count <= '0;
        else if (capture_we && !step_ok && !(&seq_err_count))
            seq_err_count <= seq_err_count + 1'b1;
    end

    // Idle tick counter: cleared by captures, saturates at the stall limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (clk_en) begin
            if (capture_we)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_MAX)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_frame_capture.sv
// LCD frame capture. Collects the four H-phase segment words from the CPU core
// into a working frame, parks completed frames in a pending buffer and swaps
// them to the front buffer whenever the renderer is not reading. The front
// frame is read out one word per clk with one cycle of latency.
module lcd_frame_capture
    import lcd_pkg::*;
#(
    parameter int STALL_TICKS = 2048,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic [1:0]       lcd_h_index,
    input  logic [15:0]      segment_a,
    input  logic [15:0]      segment_b,
    input  logic             segment_bs,
    input  logic             rd_busy,
    input  logic [1:0]       rd_h,
    output logic [SEG_W-1:0] rd_data,
    output logic             frame_valid,
    output logic             stale,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] seq_err_count
);

    frame_t    working;
    frame_t    pending_buf;
    frame_t    front;
    frame_t    done_frame;
    seg_word_t live_word;
    logic      pending;
    logic      swap;
    logic      capture_we;
    logic [1:0] capture_idx;
    logic      frame_done;
    logic      stall_hit;

    lcd_frame_seq #(
        .STALL_TICKS (STALL_TICKS),
        .CNT_W       (CNT_W)
    ) u_seq (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_en        (clk_en),
        .lcd_h_index   (lcd_h_index),
        .capture_we    (capture_we),
        .capture_idx   (capture_idx),
        .frame_done    (frame_done),
        .stall_hit     (stall_hit),
        .seq_err_count (seq_err_count)
    );

    assign live_word = {segment_bs, segment_b, segment_a};

    // A swap consumes the pending frame as it stood before this clk, so a frame
    // completing in the same clk simply becomes the new pending frame.
    assign swap = pending && !rd_busy;

    // Completed frame: working phases 0..2 plus phase 3 straight from the inputs,
    // since working[3] is only being written on this same edge.
    always_comb begin
        done_frame             = working;
        done_frame[H_PHASES-1] = live_word;
    end

    // Working frame capture, one phase per capture strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            working <= '0;
        else if (capture_we)
            working[capture_idx] <= live_word;
    end

    // Pending buffer: newest completed frame wins; overwriting an unswapped one is a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_buf <= '0;
            pending     <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (frame_done) begin
                pending_buf <= done_frame;
                pending     <= 1'b1;
                if (pending && !swap && !(&drop_count))
                    drop_count <= drop_count + 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    // Front buffer swap with a single-clk frame_valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front       <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= swap;
            if (swap) begin
                front <= pending_buf;
                if (!(&frame_count))
                    frame_count <= frame_count + 1'b1;
            end
        end
    end

    // Stale is sticky: only a fresh frame reaching the front clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stale <= 1'b0;
        else if (stall_hit)
            stale <= 1'b1;
        else if (swap)
            stale <= 1'b0;
    end

    // Registered front-buffer read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data <= '0;
        else
            rd_data <= front[rd_h];
    end

endmodule

// File: doc/lcd_frame_capture.md
Name: lcd_frame_capture

Overview:
- Sits directly downstream of the CPU core's LCD strobe outputs (segment_a, segment_b, segment_bs, lcd H index).
- Captures the segment words for each of the 4 H phases and assembles them into a complete frame.
- Triple-buffers frames: working, pending and front.
- Presents a stable front frame to the video renderer, with a busy/valid handshake and stall detection.

Parameters:
- STALL_TICKS, 2048: clk_en ticks with no H-phase change before stale asserts.
- CNT_W, 8: width of the saturating frame and error counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  32.768kHz enable, the same enable that drives the CPU core.
- lcd_h_index  in  2  current H phase from the CPU core.
- segment_a  in  16  segment word A for the current H phase.
- segment_b  in  16  segment word B for the current H phase.
- segment_bs  in  1  BS comb bit for the current H phase.
- rd_busy  in  1  renderer is reading the front frame; swaps are deferred while high.
- rd_h  in  2  read H phase.
- rd_data  out  33  front frame word {bs, b[15:0], a[15:0]} for rd_h, registered.
- frame_valid  out  1  one-clk pulse when the front frame is replaced.
- stale  out  1  no H-phase activity for STALL_TICKS clk_en ticks.
- frame_count  out  CNT_W  frames swapped to front, saturating.
- drop_count  out  CNT_W  pending frames overwritten before swap, saturating.
- seq_err_count  out  CNT_W  non-sequential H-phase steps, saturating.

Behaviour:
- Reset (async, reset_n=0): all buffers zero, prev_h=0, seen_mask=0, pending=0, stall counter=0. Outputs: rd_data=0, frame_valid=0, stale=0, all counters=0.
- All capture and stall logic advances only on clk_en. Swap, handshake and read logic run every clk.
- Capture condition: on a clk_en where lcd_h_index != prev_h.
  - working[lcd_h_index] <= {segment_bs, segment_b, segment_a}.
  - prev_h <= lcd_h_index.
  - Stall counter clears to 0.
- Sequence check: the expected step is prev_h+1 mod 4.
  - Step correct: set seen_mask[lcd_h_index].
  - Step wrong: seen_mask <= onehot(lcd_h_index) and seq_err_count increments.
- Frame complete: a capture of phase 3 with seen_mask[2:0]=3'b111 and a correct step.
  - pending_buf <= working, with phase 3 taken from the live inputs in the same cycle.
  - pending <= 1.
  - seen_mask <= 0.
  - If pending was already 1, increment drop_count; the newer frame wins.
- Swap: on any clk with pending=1 and rd_busy=0.
  - front <= pending_buf, pending <= 0.
  - frame_valid pulses high for exactly that clk.
  - frame_count increments.
  - stale clears.
- Simultaneous complete and swap in the same clk: swap uses the old pending_buf, and the new frame becomes pending. No drop is counted.
- rd_busy rising while pending: the swap waits. The front frame never changes while rd_busy=1.
- Read: rd_data <= front[rd_h] every clk, giving 1-clk latency.
- Stall counter:
  - Increments on clk_en when there is no capture and saturates at STALL_TICKS.
  - stale is high when counter == STALL_TICKS.
  - stale falls on the next swap, not merely on the next capture.
- Counter arithmetic: all counters saturate at 2^CNT_W-1 and never wrap.
- Startup: the first capture after reset compares against prev_h=0. A first index of 1 is therefore a correct step; any other first index is a sequence error.
- Reset mid-frame discards working, pending and front contents.

Decomposition:
- Shared package lcd_pkg:
  - H_PHASES=4.
  - SEG_W=33.
  - typedef seg_word_t = logic[SEG_W-1:0].
  - typedef frame_t = seg_word_t[H_PHASES].
- One natural sub-module: lcd_frame_seq. It holds prev_h, seen_mask, the sequence check, seq_err_count and the stall counter. It emits capture_we, capture_idx and frame_done to the buffering top level.

Test Plan:
1. Phases 1,2,3,0,1,2,3 with a=16'h0001<<h, b=16'h8000>>h, bs=h[0], rd_busy=0.
   - frame_valid pulses once, 1 clk after the capture of the second phase 3.
   - rd_h=2 reads {1'b0, 16'h2000, 16'h0004} one clk later.
   - frame_count=1.
2. Hold rd_busy=1, complete two frames, then drop rd_busy.
   - drop_count=1 and exactly one frame_valid pulse.
   - Front holds the second frame's data.
3. Phase sequence 1,2,0,1,2,3.
   - seq_err_count=1 and no frame_valid on the first 3.
   - Frame completes only after 0,1,2,3 are seen in order.
4. Hold lcd_h_index constant for 2048 clk_en ticks.
   - stale rises on tick 2048.
   - stale stays high through captures and falls on the next frame_valid.
5. Assert reset_n=0 asynchronously (no clk edge) mid-frame with pending=1.
   - All outputs are 0 immediately.
   - After release, the first frame_valid needs a full 4-phase sequence.
6. Frame completion coinciding with rd_busy falling.
   - The older frame swaps in and the newer one stays pending.
   - drop_count is unchanged; a second frame_valid follows on the next clk.
